// File: rtl/contador_decadico_decr_pkg.sv
// Shared definitions for the AC-I decade counter set.
// BCD digit limits and the nibble type used by every counter.
package contador_decadico_decr_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef logic [3:0] digit_t;

    // Loaded nibbles above nine are forced back into the BCD range.
    function automatic digit_t bcd_clamp(input digit_t v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/contador_decadico_decr_digit.sv
// One BCD down-counting digit: clamp-on-load, decrement, 0 -> 9 wrap.
// Preset forces the digit to nine asynchronously.
module bcd_down_digit
    import contador_decadico_decr_pkg::*;
(
    input  logic       clk,
    input  logic       preset,
    input  logic       dec,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       is_zero
);

    digit_t q_r;

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            q_r <= BCD_MAX;
        end else if (ld) begin
            q_r <= bcd_clamp(ld_val);
        end else if (dec) begin
            q_r <= (q_r == BCD_MIN) ? BCD_MAX : q_r - 4'd1;
        end
    end

    assign q       = q_r;
    assign is_zero = (q_r == BCD_MIN);

endmodule

// File: rtl/contador_decadico_decr.sv
// Synchronous cascadable BCD down counter with parallel load,
// borrow output for chaining and optional stop-at-zero mode.
module contador_decadico_decr
    import contador_decadico_decr_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int WRAP   = 1
) (
    input  logic                  clk,
    input  logic                  preset,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  zero,
    output logic                  borrow,
    output logic                  underflow
);

    localparam bit WRAP_EN = (WRAP != 0);

    logic [DIGITS-1:0] is_zero;
    logic [DIGITS-1:0] dec;
    logic [DIGITS:0]   low_zero;
    logic              count_en;
    logic              underflow_r;

    // low_zero[i]: every digit below i reads zero.
    assign low_zero[0] = 1'b1;

    // Stop-at-zero mode blocks the all-zero -> all-nines step.
    assign count_en = en & ~load & (WRAP_EN | ~zero);

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            assign low_zero[i+1] = low_zero[i] & is_zero[i];
            assign dec[i]        = count_en & low_zero[i];

            bcd_down_digit u_digit (
                .clk     (clk),
                .preset  (preset),
                .dec     (dec[i]),
                .ld      (load),
                .ld_val  (load_val[4*i +: 4]),
                .q       (count[4*i +: 4]),
                .is_zero (is_zero[i])
            );
        end
    endgenerate

    assign zero   = low_zero[DIGITS];
    assign borrow = en & zero;

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            underflow_r <= 1'b0;
        end else if (load) begin
            underflow_r <= 1'b0;
        end else if (en && zero && WRAP_EN) begin
            underflow_r <= 1'b1;
        end
    end

    assign underflow = underflow_r;

endmodule

// File: tb/tb_contador_decadico_decr.sv
// Bench for contador_decadico_decr: integer reference model,
// WRAP=1/WRAP=0 instances and a two-stage DIGITS=1 cascade.
module tb_contador_decadico_decr;

    logic       clk = 1'b0;
    logic       preset;
    logic       en, load;
    logic [7:0] load_val;
    logic       en_c, load_c;
    logic [7:0] load_val_c;

    logic [7:0] cnt1, cnt0, cntr;
    logic       z1, b1, u1, z0, b0, u0, zr, br, ur;
    logic [3:0] clo, chi;
    logic       zlo, blo, ulo, zhi, bhi, uhi;

    int  checks = 0;
    int  errors = 0;
    bit  run = 0;
    int  m1v = 99, m0v = 99, mrv = 99;
    bit  m1u = 0, m0u = 0, mru = 0;

    always #5 clk = ~clk;

    contador_decadico_decr #(.DIGITS(2), .WRAP(1)) u_w1 (
        .clk(clk), .preset(preset), .en(en), .load(load),
        .load_val(load_val), .count(cnt1), .zero(z1),
        .borrow(b1), .underflow(u1));

    contador_decadico_decr #(.DIGITS(2), .WRAP(0)) u_w0 (
        .clk(clk), .preset(preset), .en(en), .load(load),
        .load_val(load_val), .count(cnt0), .zero(z0),
        .borrow(b0), .underflow(u0));

    contador_decadico_decr #(.DIGITS(2), .WRAP(1)) u_ref (
        .clk(clk), .preset(preset), .en(en_c), .load(load_c),
        .load_val(load_val_c), .count(cntr), .zero(zr),
        .borrow(br), .underflow(ur));

    contador_decadico_decr #(.DIGITS(1), .WRAP(1)) u_lo (
        .clk(clk), .preset(preset), .en(en_c), .load(load_c),
        .load_val(load_val_c[3:0]), .count(clo), .zero(zlo),
        .borrow(blo), .underflow(ulo));

    contador_decadico_decr #(.DIGITS(1), .WRAP(1)) u_hi (
        .clk(clk), .preset(preset), .en(blo), .load(load_c),
        .load_val(load_val_c[7:4]), .count(chi), .zero(zhi),
        .borrow(bhi), .underflow(uhi));

    function automatic int clampv(input logic [7:0] lv);
        int hi, lo;
        hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
        lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
        return hi * 10 + lo;
    endfunction

    function automatic int bcd(input int v);
        return ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    function automatic int nxt(input int v, input bit e, input bit ld,
                               input logic [7:0] lv, input bit wrap);
        if (ld) return clampv(lv);
        if (!e) return v;
        if (v == 0) return wrap ? 99 : 0;
        return v - 1;
    endfunction

    function automatic bit nuf(input int v, input bit uf, input bit e,
                               input bit ld, input bit wrap);
        if (ld) return 1'b0;
        if (e && v == 0 && wrap) return 1'b1;
        return uf;
    endfunction

    task automatic cmp(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, got, exp);
        end
    endtask

    // Reference model: whole-number value per instance.
    always @(posedge clk or posedge preset) begin
        if (preset) begin
            m1v <= 99; m0v <= 99; mrv <= 99;
            m1u <= 0;  m0u <= 0;  mru <= 0;
        end else begin
            m1v <= nxt(m1v, en, load, load_val, 1'b1);
            m1u <= nuf(m1v, m1u, en, load, 1'b1);
            m0v <= nxt(m0v, en, load, load_val, 1'b0);
            m0u <= nuf(m0v, m0u, en, load, 1'b0);
            mrv <= nxt(mrv, en_c, load_c, load_val_c, 1'b1);
            mru <= nuf(mrv, mru, en_c, load_c, 1'b1);
        end
    end

    always @(negedge clk) begin
        if (run) begin
            cmp("w1_count", int'(cnt1), bcd(m1v));
            cmp("w1_zero", int'(z1), int'(m1v == 0));
            cmp("w1_borrow", int'(b1), int'(en && m1v == 0));
            cmp("w1_underflow", int'(u1), int'(m1u));
            cmp("w0_count", int'(cnt0), bcd(m0v));
            cmp("w0_zero", int'(z0), int'(m0v == 0));
            cmp("w0_borrow", int'(b0), int'(en && m0v == 0));
            cmp("w0_underflow", int'(u0), int'(m0u));
            cmp("ref_count", int'(cntr), bcd(mrv));
            cmp("ref_borrow", int'(br), int'(en_c && mrv == 0));
            cmp("cas_count", int'({chi, clo}), bcd(mrv));
            cmp("cas_borrow", int'(bhi), int'(en_c && mrv == 0));
            cmp("cas_underflow", int'(uhi), int'(mru));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input bit e, input bit ld, input logic [7:0] lv);
        en = e;
        load = ld;
        load_val = lv;
        tick();
    endtask

    initial begin
        preset = 1'b1;
        en = 0; load = 0; load_val = 8'h00;
        en_c = 0; load_c = 0; load_val_c = 8'h00;
        repeat (2) @(posedge clk);
        #2 preset = 1'b0;
        run = 1;
        cmp("reset_count", int'(cnt1), 'h99);
        cmp("reset_zero", int'(z1), 0);
        cmp("reset_underflow", int'(u1), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 8'h00);
            cmp("idle_count", int'(cnt1), 'h99);
        end

        cyc(0, 1, 8'h21);
        cyc(1, 0, 8'h00); cmp("borrow_seq0", int'(cnt1), 'h20);
        cyc(1, 0, 8'h00); cmp("borrow_seq1", int'(cnt1), 'h19);
        cyc(1, 0, 8'h00); cmp("borrow_seq2", int'(cnt1), 'h18);

        cyc(0, 1, 8'h01);
        cyc(1, 0, 8'h00);
        cmp("wrap_zero_cnt", int'(cnt1), 'h00);
        cmp("wrap_zero_flag", int'(z1), 1);
        cmp("wrap_borrow", int'(b1), 1);
        cyc(1, 0, 8'h00);
        cmp("wrap_nines", int'(cnt1), 'h99);
        cmp("wrap_underflow", int'(u1), 1);
        cyc(0, 0, 8'h00);
        cmp("uf_sticky", int'(u1), 1);
        cyc(0, 1, 8'h50);
        cmp("uf_cleared", int'(u1), 0);
        cmp("load_50", int'(cnt1), 'h50);

        cyc(0, 1, 8'h02);
        cyc(1, 0, 8'h00); cmp("hold_seq0", int'(cnt0), 'h01);
        cyc(1, 0, 8'h00); cmp("hold_seq1", int'(cnt0), 'h00);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 8'h00);
            cmp("hold_zero", int'(cnt0), 'h00);
            cmp("hold_borrow", int'(b0), 1);
            cmp("hold_underflow", int'(u0), 0);
        end

        cyc(1, 1, 8'hFA);
        cmp("clamp_load", int'(cnt1), 'h99);

        cyc(1, 0, 8'h00);
        cyc(1, 0, 8'h00);
        cmp("pre_preset", int'(cnt1), 'h97);
        #1 preset = 1'b1;
        #1 cmp("async_preset", int'(cnt1), 'h99);
        cmp("async_preset_w0", int'(cnt0), 'h99);
        #4 preset = 1'b0;
        #1 cmp("preset_release", int'(cnt1), 'h99);
        tick();
        cmp("after_release", int'(cnt1), 'h98);

        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 9) < 7),
                ($urandom_range(0, 9) == 0),
                8'($urandom));
        end
        en = 0; load = 0;

        load_val_c = 8'h00;
        load_c = 1;
        tick();
        load_c = 0;
        en_c = 1;
        tick();
        cmp("cascade_wrap", int'({chi, clo}), 'h99);
        cmp("cascade_ref", int'(cntr), 'h99);
        for (int i = 0; i < 120; i++) begin
            en_c = ($urandom_range(0, 9) < 8);
            load_c = ($urandom_range(0, 29) == 0);
            load_val_c = 8'($urandom);
            tick();
        end
        en_c = 0; load_c = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
